// File: rtl/ece429_mem_pkg.sv
// Shared definitions for the fetch/memory request interface: access-size codes,
// reset PC and the responder FSM state type.
package ece429_mem_pkg;

  localparam logic [1:0] ACC_WORD  = 2'b11;
  localparam logic [1:0] ACC_HALF  = 2'b10;
  localparam logic [1:0] ACC_BYTE0 = 2'b00;
  localparam logic [1:0] ACC_BYTE1 = 2'b01;

  localparam logic [31:0] RESET_PC = 32'h80020000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Bytes are never misaligned; halves need an even address, words a multiple of 4.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] byte_off);
    logic r;
    case (size)
      ACC_WORD: r = (byte_off != 2'b00);
      ACC_HALF: r = byte_off[0];
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ece429_mem_lane_align.sv
// Big-endian byte-lane steering: builds the write merge mask/lane data and
// extracts right-justified, zero-extended read data from a stored word.
module ece429_mem_lane_align
  import ece429_mem_pkg::*;
(
  input  logic [0:1]  i_byte_off,
  input  logic [0:1]  i_size,
  input  logic [0:31] i_wdata,
  input  logic [0:31] i_rword,
  output logic [0:31] o_wmask,
  output logic [0:31] o_wlane,
  output logic [0:31] o_rdata
);

  logic [4:0]  w_shift;
  logic [0:31] w_keep;

  // Byte offset 0 is the most significant lane, so the shift grows as the offset shrinks.
  always_comb begin
    w_shift = 5'd0;
    w_keep  = 32'hFFFF_FFFF;
    case (i_size)
      ACC_WORD: begin
        w_shift = 5'd0;
        w_keep  = 32'hFFFF_FFFF;
      end
      ACC_HALF: begin
        w_shift = {~i_byte_off[0], 4'b0000};
        w_keep  = 32'h0000_FFFF;
      end
      default: begin
        w_shift = {~i_byte_off, 3'b000};
        w_keep  = 32'h0000_00FF;
      end
    endcase
  end

  assign o_wmask = w_keep << w_shift;
  assign o_wlane = (i_wdata & w_keep) << w_shift;
  assign o_rdata = (i_rword >> w_shift) & w_keep;

endmodule

// File: rtl/ece429_mem_responder.sv
// Memory-side responder: word array with big-endian sub-word access, answering
// each accepted request after LATENCY cycles; busy_out stalls the requester.
module ece429_mem_responder
  import ece429_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h80020000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req_in,
  input  logic [0:31] addr_in,
  input  logic        rw_in,
  input  logic [0:1]  access_size_in,
  input  logic [0:31] data_in,
  output logic        busy_out,
  output logic        valid_out,
  output logic [0:31] data_out,
  output logic        error_out
);

  localparam int          IDX_W      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  LAT_LOAD   = 4'(LATENCY - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic [0:31] r_resp_data;
  logic        r_resp_err;
  logic [0:31] r_mem [DEPTH_WORDS];

  logic [0:31]      w_offset;
  logic [IDX_W-1:0] w_index;
  logic             w_out_of_range;
  logic             w_misaligned;
  logic             w_err;
  logic             w_accept;
  logic [0:31]      w_word;
  logic [0:31]      w_wmask;
  logic [0:31]      w_wlane;
  logic [0:31]      w_rdata;

  // Addresses below the base wrap to huge offsets and so fall out of range too.
  assign w_offset       = addr_in - BASE_ADDR;
  assign w_index        = w_offset[(30 - IDX_W) +: IDX_W];
  assign w_out_of_range = (w_offset >= SPAN_BYTES);
  assign w_misaligned   = is_misaligned(access_size_in, addr_in[30:31]);
  assign w_err          = w_out_of_range | w_misaligned;
  assign w_accept       = req_in & (r_state != WAIT) & ~rst_in;
  assign w_word         = r_mem[w_index];

  ece429_mem_lane_align u_lane_align (
    .i_byte_off (addr_in[30:31]),
    .i_size     (access_size_in),
    .i_wdata    (data_in),
    .i_rword    (w_word),
    .o_wmask    (w_wmask),
    .o_wlane    (w_wlane),
    .o_rdata    (w_rdata)
  );

  // Writes commit on the acceptance edge; faulting writes never touch the array.
  always_ff @(posedge clk_in) begin
    if (w_accept && rw_in && !w_err) begin
      r_mem[w_index] <= (w_word & ~w_wmask) | w_wlane;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_resp_data <= '0;
      r_resp_err  <= 1'b0;
    end else if (w_accept) begin
      r_resp_err  <= w_err;
      r_resp_data <= (w_err || rw_in) ? '0 : w_rdata;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // RESP accepts like IDLE, so single-cycle latency sustains one response per cycle.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE, RESP: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_next = RESP;
          end else begin
            w_state_next = WAIT;
            w_cnt_next   = LAT_LOAD;
          end
        end else begin
          w_state_next = IDLE;
        end
      end
      WAIT: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_next = RESP;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign busy_out  = (r_state == WAIT);
  assign valid_out = (r_state == RESP);
  assign data_out  = valid_out ? r_resp_data : '0;
  assign error_out = valid_out & r_resp_err;

endmodule

// File: tb/tb_ece429_mem_responder.sv
// Self-checking bench: one LATENCY=1 and one LATENCY=4 responder, directed
// scenarios plus randomized back-to-back traffic against a byte-level model.
module tb_ece429_mem_responder;
  import ece429_mem_pkg::*;

  localparam logic [31:0] BASE  = 32'h80020000;
  localparam int          DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, req1, rw1, busy1, valid1, err1;
  logic [0:1]  size1;
  logic [0:31] addr1, din1, dout1;
  logic        rst4, req4, rw4, busy4, valid4, err4;
  logic [0:1]  size4;
  logic [0:31] addr4, din4, dout4;

  int nChecks = 0;
  int nFail   = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  ece429_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (
    .clk_in(clk), .rst_in(rst1), .req_in(req1), .addr_in(addr1), .rw_in(rw1),
    .access_size_in(size1), .data_in(din1), .busy_out(busy1), .valid_out(valid1),
    .data_out(dout1), .error_out(err1)
  );

  ece429_mem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(4)) dut4 (
    .clk_in(clk), .rst_in(rst4), .req_in(req4), .addr_in(addr4), .rw_in(rw4),
    .access_size_in(size4), .data_in(din4), .busy_out(busy4), .valid_out(valid4),
    .data_out(dout4), .error_out(err4)
  );

  task automatic drive(input int sel, input logic req, input logic rw, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] data);
    if (sel == 1) begin
      req1 = req; rw1 = rw; size1 = size; addr1 = addr; din1 = data;
    end else begin
      req4 = req; rw4 = rw; size4 = size; addr4 = addr; din4 = data;
    end
  endtask

  // One request, then wait (bounded) for its response; lat=0 means no response seen.
  task automatic issue(input int sel, input logic rw, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] data, output logic [31:0] rdata, output logic rerr,
                       output int lat, output int busyCycles);
    @(negedge clk);
    drive(sel, 1'b1, rw, size, addr, data);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    lat = 0; busyCycles = 0; rdata = 'x; rerr = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      if ((sel == 1 ? busy1 : busy4) === 1'b1) busyCycles++;
      if ((sel == 1 ? valid1 : valid4) === 1'b1) begin
        lat   = i;
        rdata = (sel == 1) ? dout1 : dout4;
        rerr  = (sel == 1) ? err1 : err4;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst1 = 1'b1; rst4 = 1'b1;
    drive(1, 1'b1, 1'b0, ACC_WORD, BASE, 32'h0);
    drive(4, 1'b1, 1'b0, ACC_WORD, BASE, 32'h0);
    repeat (3) @(negedge clk);
    nChecks++; if (busy1 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy1 got=%b exp=0", busy1); end
    nChecks++; if (valid1 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid1 got=%b exp=0", valid1); end
    nChecks++; if (dout1 !== 32'h0) begin nFail++; $display("[TB] FAIL reset_data1 got=%h exp=0", dout1); end
    nChecks++; if (err1 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_err1 got=%b exp=0", err1); end
    nChecks++; if (busy4 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_busy4 got=%b exp=0", busy4); end
    nChecks++; if (valid4 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid4 got=%b exp=0", valid4); end
    nChecks++; if (dout4 !== 32'h0) begin nFail++; $display("[TB] FAIL reset_data4 got=%h exp=0", dout4); end
    nChecks++; if (err4 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_err4 got=%b exp=0", err4); end
    rst1 = 1'b0; rst4 = 1'b0;
    drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(4, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    nChecks++; if (valid1 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_noaccept1 got=%b exp=0", valid1); end
    nChecks++; if (busy4 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_noaccept4 got=%b exp=0", busy4); end
  endtask

  task automatic test_word_rw();
    logic [31:0] d; logic e; int lat, bc;
    issue(1, 1'b1, ACC_WORD, BASE, 32'hDEADBEEF, d, e, lat, bc);
    nChecks++; if (lat != 1) begin nFail++; $display("[TB] FAIL wr_latency got=%0d exp=1", lat); end
    nChecks++; if (e !== 1'b0 || d !== 32'h0) begin nFail++; $display("[TB] FAIL wr_ack got=%h/%b exp=0/0", d, e); end
    issue(1, 1'b0, ACC_WORD, BASE, 32'h0, d, e, lat, bc);
    nChecks++; if (lat != 1) begin nFail++; $display("[TB] FAIL rd_latency got=%0d exp=1", lat); end
    nChecks++; if (d !== 32'hDEADBEEF) begin nFail++; $display("[TB] FAIL rd_data got=%h exp=deadbeef", d); end
    nChecks++; if (e !== 1'b0) begin nFail++; $display("[TB] FAIL rd_err got=%b exp=0", e); end
    nChecks++; if (bc != 0) begin nFail++; $display("[TB] FAIL lat1_busy got=%0d exp=0", bc); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] d; logic e; int lat, bc;
    issue(1, 1'b1, ACC_WORD, BASE, 32'h11223344, d, e, lat, bc);
    issue(1, 1'b1, ACC_BYTE1, BASE + 2, 32'h123456AA, d, e, lat, bc);
    issue(1, 1'b0, ACC_WORD, BASE, 32'h0, d, e, lat, bc);
    nChecks++; if (d !== 32'h1122AA44) begin nFail++; $display("[TB] FAIL byte_merge got=%h exp=1122aa44", d); end
    issue(1, 1'b0, ACC_HALF, BASE + 2, 32'h0, d, e, lat, bc);
    nChecks++; if (d !== 32'h0000AA44) begin nFail++; $display("[TB] FAIL half_read2 got=%h exp=0000aa44", d); end
    issue(1, 1'b0, ACC_BYTE0, BASE + 1, 32'h0, d, e, lat, bc);
    nChecks++; if (d !== 32'h00000022) begin nFail++; $display("[TB] FAIL byte_read1 got=%h exp=00000022", d); end
    issue(1, 1'b1, ACC_HALF, BASE, 32'hFFFFBEEF, d, e, lat, bc);
    issue(1, 1'b0, ACC_WORD, BASE, 32'h0, d, e, lat, bc);
    nChecks++; if (d !== 32'hBEEFAA44) begin nFail++; $display("[TB] FAIL half_merge got=%h exp=beefaa44", d); end
  endtask

  task automatic test_latency();
    logic [31:0] d; logic e; int lat, bc, extra;
    issue(4, 1'b1, ACC_WORD, BASE + 8, 32'h0BADF00D, d, e, lat, bc);
    nChecks++; if (lat != 4) begin nFail++; $display("[TB] FAIL l4_wr_latency got=%0d exp=4", lat); end
    nChecks++; if (bc != 3) begin nFail++; $display("[TB] FAIL l4_busy_cycles got=%0d exp=3", bc); end
    @(negedge clk);
    drive(4, 1'b1, 1'b0, ACC_WORD, BASE + 8, 32'h0);
    @(negedge clk);
    drive(4, 1'b1, 1'b1, ACC_WORD, BASE + 8, 32'h55555555);
    nChecks++; if (busy4 !== 1'b1) begin nFail++; $display("[TB] FAIL l4_busy_c1 got=%b exp=1", busy4); end
    @(negedge clk);
    nChecks++; if (busy4 !== 1'b1) begin nFail++; $display("[TB] FAIL l4_busy_c2 got=%b exp=1", busy4); end
    @(negedge clk);
    nChecks++; if (busy4 !== 1'b1 || valid4 !== 1'b0) begin nFail++; $display("[TB] FAIL l4_c3 busy/valid got=%b/%b exp=1/0", busy4, valid4); end
    drive(4, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    nChecks++; if (valid4 !== 1'b1 || busy4 !== 1'b0) begin nFail++; $display("[TB] FAIL l4_c4 valid/busy got=%b/%b exp=1/0", valid4, busy4); end
    nChecks++; if (dout4 !== 32'h0BADF00D) begin nFail++; $display("[TB] FAIL l4_rd_data got=%h exp=0badf00d", dout4); end
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid4 === 1'b1) extra++;
    end
    nChecks++; if (extra != 0) begin nFail++; $display("[TB] FAIL l4_ignored_req got=%0d responses exp=0", extra); end
    issue(4, 1'b0, ACC_WORD, BASE + 8, 32'h0, d, e, lat, bc);
    nChecks++; if (d !== 32'h0BADF00D) begin nFail++; $display("[TB] FAIL l4_no_write_when_busy got=%h exp=0badf00d", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int lat, bc;
    issue(1, 1'b1, ACC_WORD, BASE + 16, 32'h13579BDF, d, e, lat, bc);
    issue(1, 1'b0, ACC_WORD, BASE + 2, 32'h0, d, e, lat, bc);
    nChecks++; if (e !== 1'b1 || d !== 32'h0 || lat != 1) begin nFail++; $display("[TB] FAIL misal_word_rd got=%h/%b/%0d exp=0/1/1", d, e, lat); end
    issue(1, 1'b1, ACC_WORD, BASE + 18, 32'hFFFFFFFF, d, e, lat, bc);
    nChecks++; if (e !== 1'b1) begin nFail++; $display("[TB] FAIL misal_word_wr_err got=%b exp=1", e); end
    issue(1, 1'b1, ACC_HALF, BASE + 17, 32'h0000FFFF, d, e, lat, bc);
    nChecks++; if (e !== 1'b1) begin nFail++; $display("[TB] FAIL misal_half_wr_err got=%b exp=1", e); end
    issue(1, 1'b0, ACC_WORD, BASE + 16, 32'h0, d, e, lat, bc);
    nChecks++; if (d !== 32'h13579BDF) begin nFail++; $display("[TB] FAIL misal_unchanged got=%h exp=13579bdf", d); end
    issue(1, 1'b1, ACC_WORD, BASE + DEPTH * 4, 32'hA5A5A5A5, d, e, lat, bc);
    nChecks++; if (e !== 1'b1 || d !== 32'h0) begin nFail++; $display("[TB] FAIL oor_wr got=%h/%b exp=0/1", d, e); end
    issue(1, 1'b0, ACC_WORD, BASE, 32'h0, d, e, lat, bc);
    nChecks++; if (d !== 32'hBEEFAA44) begin nFail++; $display("[TB] FAIL oor_no_alias got=%h exp=beefaa44", d); end
    issue(1, 1'b1, ACC_WORD, BASE + DEPTH * 4 - 4, 32'h600DCAFE, d, e, lat, bc);
    nChecks++; if (e !== 1'b0) begin nFail++; $display("[TB] FAIL last_word_wr_err got=%b exp=0", e); end
    issue(1, 1'b0, ACC_BYTE0, BASE + DEPTH * 4 - 1, 32'h0, d, e, lat, bc);
    nChecks++; if (e !== 1'b0 || d !== 32'h000000FE) begin nFail++; $display("[TB] FAIL last_byte_rd got=%h/%b exp=000000fe/0", d, e); end
    issue(1, 1'b0, ACC_WORD, 32'h8001FFFC, 32'h0, d, e, lat, bc);
    nChecks++; if (e !== 1'b1 || d !== 32'h0) begin nFail++; $display("[TB] FAIL below_base_rd got=%h/%b exp=0/1", d, e); end
    issue(1, 1'b1, ACC_WORD, 32'h8001FFFC, 32'h0, d, e, lat, bc);
    issue(1, 1'b0, ACC_WORD, BASE + DEPTH * 4 - 4, 32'h0, d, e, lat, bc);
    nChecks++; if (d !== 32'h600DCAFE) begin nFail++; $display("[TB] FAIL below_base_no_alias got=%h exp=600dcafe", d); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] d; logic e; int lat, bc, seen;
    issue(4, 1'b1, ACC_WORD, BASE + 12, 32'hCAFEF00D, d, e, lat, bc);
    @(negedge clk);
    drive(4, 1'b1, 1'b0, ACC_WORD, BASE + 12, 32'h0);
    @(negedge clk);
    drive(4, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    @(negedge clk);
    rst4 = 1'b1;
    @(negedge clk);
    nChecks++; if (busy4 !== 1'b0 || valid4 !== 1'b0) begin nFail++; $display("[TB] FAIL rst_wait busy/valid got=%b/%b exp=0/0", busy4, valid4); end
    rst4 = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (valid4 === 1'b1) seen++;
    end
    nChecks++; if (seen != 0) begin nFail++; $display("[TB] FAIL rst_wait_no_valid got=%0d exp=0", seen); end
    issue(4, 1'b0, ACC_WORD, BASE + 12, 32'h0, d, e, lat, bc);
    nChecks++; if (d !== 32'hCAFEF00D || lat != 4) begin nFail++; $display("[TB] FAIL rst_wait_retained got=%h/%0d exp=cafef00d/4", d, lat); end
  endtask

  // Byte-addressed big-endian model; region offsets 256..319 are pre-filled.
  task automatic test_back_to_back();
    logic [7:0]  mb [int];
    exp_t        q[$];
    exp_t        x, ex;
    logic [31:0] addr, data, off, v;
    logic [1:0]  size;
    logic        rw, err;
    int          nb, pick;
    for (int k = 0; k < 336; k++) begin
      if (k < 16) begin
        addr = BASE + 256 + 4 * k; size = ACC_WORD; rw = 1'b1; data = $urandom;
      end else begin
        pick = $urandom_range(0, 9);
        if (pick == 0)      addr = BASE - 4 + $urandom_range(0, 3);
        else if (pick == 1) addr = BASE + DEPTH * 4 + $urandom_range(0, 7);
        else                addr = BASE + 256 + $urandom_range(0, 63);
        size = 2'($urandom_range(0, 3)); rw = 1'($urandom_range(0, 1)); data = $urandom;
      end
      off = addr - BASE;
      nb  = (size == ACC_WORD) ? 4 : (size == ACC_HALF) ? 2 : 1;
      err = (off >= DEPTH * 4) || (size == ACC_HALF && off[0]) || (size == ACC_WORD && off[1:0] != 2'b00);
      x.d = 32'h0; x.e = err;
      if (!err && rw) begin
        for (int b = 0; b < nb; b++) mb[int'(off) + b] = data[8 * (nb - 1 - b) +: 8];
      end else if (!err) begin
        v = 32'h0;
        for (int b = 0; b < nb; b++) v = (v << 8) | {24'h0, mb[int'(off) + b]};
        x.d = v;
      end
      @(negedge clk);
      if (q.size() > 0) begin
        ex = q.pop_front();
        nChecks++;
        if (valid1 !== 1'b1 || dout1 !== ex.d || err1 !== ex.e) begin
          nFail++; $display("[TB] FAIL b2b_resp k=%0d got=%b/%h/%b exp=1/%h/%b", k, valid1, dout1, err1, ex.d, ex.e);
        end
      end
      drive(1, 1'b1, rw, size, addr, data);
      q.push_back(x);
    end
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    ex = q.pop_front();
    nChecks++;
    if (valid1 !== 1'b1 || dout1 !== ex.d || err1 !== ex.e) begin
      nFail++; $display("[TB] FAIL b2b_last got=%b/%h/%b exp=1/%h/%b", valid1, dout1, err1, ex.d, ex.e);
    end
    @(negedge clk);
    nChecks++; if (valid1 !== 1'b0) begin nFail++; $display("[TB] FAIL b2b_idle got=%b exp=0", valid1); end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst1 = 1'b1; rst4 = 1'b1;
    drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(4, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_latency();
    test_errors();
    test_reset_mid_wait();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
